// File: rtl/spi_byte_link.sv
// SPI mode-0 slave byte engine: oversampled SCK/SSEL/MOSI, byte strobe out, one-byte response hold.
// Define SPI_LSB_FIRST_EN to shift bytes LSB first on both MOSI and MISO (default MSB first).
`timescale 1ns/1ps
module spi_byte_link #(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] IDLE_FILL   = 8'hFF
) (
  input  logic       clock_50,
  input  logic       reset,
  input  logic       SCK,
  input  logic       SSEL,
  input  logic       MOSI,
  output logic       MISO,
  output logic       byte_received,
  output logic [7:0] byte_data_received,
  input  logic       byte_send_ready,
  input  logic [7:0] byte_send,
  output logic       byte_sent,
  output logic       ssel_active
);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sck_sync;
  logic [SYNC_STAGES-1:0] ssel_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic                   sck_prev;
  logic                   ssel_prev;
  logic [2:0]             bit_cnt;
  logic [7:0]             rx_shift;
  logic [7:0]             tx_shift;
  logic [7:0]             tx_hold;
  logic                   tx_hold_valid;

  logic       sck_s, ssel_s, mosi_s;
  logic       sck_rise, sck_fall, ssel_fall, ssel_rise;
  logic [7:0] rx_next, tx_next, reload_value;
  logic       tx_bit, reload;

  assign sck_s     = sck_sync[SYNC_STAGES-1];
  assign ssel_s    = ssel_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign sck_rise  = sck_s & ~sck_prev;
  assign sck_fall  = ~sck_s & sck_prev;
  assign ssel_fall = ~ssel_s & ssel_prev;
  assign ssel_rise = ssel_s & ~ssel_prev;

`ifdef SPI_LSB_FIRST_EN
  assign rx_next = {mosi_s, rx_shift[7:1]};
  assign tx_next = {1'b0, tx_shift[7:1]};
  assign tx_bit  = tx_shift[0];
`else
  assign rx_next = {rx_shift[6:0], mosi_s};
  assign tx_next = {tx_shift[6:0], 1'b0};
  assign tx_bit  = tx_shift[7];
`endif

  // The shifter is refilled on select and after the falling edge that ends each byte.
  assign reload_value = tx_hold_valid ? tx_hold : IDLE_FILL;
  assign reload = ((state == IDLE) && ssel_fall) ||
                  ((state == ACTIVE) && !ssel_rise && sck_fall && (bit_cnt == 3'd0));

  assign MISO = ssel_active ? tx_bit : 1'bz;

  always_ff @(posedge clock_50 or negedge reset) begin
    if (!reset) begin
      sck_sync  <= '0;
      ssel_sync <= '1;
      mosi_sync <= '0;
      sck_prev  <= 1'b0;
      ssel_prev <= 1'b1;
    end else begin
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], SCK};
      ssel_sync <= {ssel_sync[SYNC_STAGES-2:0], SSEL};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], MOSI};
      sck_prev  <= sck_s;
      ssel_prev <= ssel_s;
    end
  end

  always_ff @(posedge clock_50 or negedge reset) begin
    if (!reset) begin
      state              <= IDLE;
      ssel_active        <= 1'b0;
      bit_cnt            <= 3'd0;
      rx_shift           <= 8'h00;
      tx_shift           <= IDLE_FILL;
      tx_hold            <= 8'h00;
      tx_hold_valid      <= 1'b0;
      byte_received      <= 1'b0;
      byte_sent          <= 1'b0;
      byte_data_received <= 8'h00;
    end else begin
      byte_received <= 1'b0;
      byte_sent     <= 1'b0;

      if (reload) begin
        tx_shift <= reload_value;
        if (tx_hold_valid) begin
          byte_sent     <= 1'b1;
          tx_hold_valid <= 1'b0;
        end
      end

      // A fresh write beats a same-cycle consume, so the new byte stays pending.
      if (byte_send_ready) begin
        tx_hold       <= byte_send;
        tx_hold_valid <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (ssel_fall) begin
            state       <= ACTIVE;
            ssel_active <= 1'b1;
            bit_cnt     <= 3'd0;
          end
        end
        ACTIVE: begin
          if (ssel_rise) begin
            state       <= IDLE;
            ssel_active <= 1'b0;
            bit_cnt     <= 3'd0;
          end else begin
            if (sck_rise) begin
              rx_shift <= rx_next;
              bit_cnt  <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                byte_data_received <= rx_next;
                byte_received      <= 1'b1;
              end
            end
            if (sck_fall && (bit_cnt != 3'd0)) begin
              tx_shift <= tx_next;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_byte_link.sv
// Scoreboard bench for spi_byte_link: acts as a 5 MHz SPI master and checks strobes, data, latency and MISO.
`timescale 1ns/1ps
module tb_spi_byte_link;

  logic       clock_50 = 1'b0;
  logic       reset = 1'b0;
  logic       SCK = 1'b0;
  logic       SSEL = 1'b1;
  logic       MOSI = 1'b0;
  logic       byte_send_ready = 1'b0;
  logic [7:0] byte_send = 8'h00;
  wire        miso_w;
  logic       byte_received;
  logic       byte_sent;
  logic       ssel_active;
  logic [7:0] byte_data_received;

  int         tests = 0;
  int         failures = 0;
  int         cycle = 0;
  int         rise8_cycle = 0;
  int         sent_count = 0;
  logic [7:0] rx_q[$];
  logic [7:0] tx_q[$];
  logic [7:0] rx_exp;

  // A released MISO reads as 0; a driven idle-fill bit would read as 1.
  pulldown (miso_w);

  spi_byte_link dut (
    .clock_50          (clock_50),
    .reset             (reset),
    .SCK               (SCK),
    .SSEL              (SSEL),
    .MOSI              (MOSI),
    .MISO              (miso_w),
    .byte_received     (byte_received),
    .byte_data_received(byte_data_received),
    .byte_send_ready   (byte_send_ready),
    .byte_send         (byte_send),
    .byte_sent         (byte_sent),
    .ssel_active       (ssel_active)
  );

  always #10 clock_50 = ~clock_50;

  always @(posedge clock_50) cycle++;

  // Every strobe must match the oldest byte the master completed, three clocks after its 8th rising SCK.
  always @(negedge clock_50) begin
    if (byte_sent) sent_count++;
    if (byte_received) begin
      tests++;
      if (rx_q.size() == 0) begin
        failures++;
        $display("[TB] FAIL rx_unexpected_strobe: got strobe with data %02h, required no strobe", byte_data_received);
      end else begin
        rx_exp = rx_q.pop_front();
        if (byte_data_received !== rx_exp) begin
          failures++;
          $display("[TB] FAIL rx_data: got %02h, required %02h", byte_data_received, rx_exp);
        end
        tests++;
        if ((cycle - rise8_cycle) !== 3) begin
          failures++;
          $display("[TB] FAIL rx_latency: got %0d clocks, required 3", cycle - rise8_cycle);
        end
      end
    end
  end

  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog: simulation still running at time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic int bit_index(input int i);
`ifdef SPI_LSB_FIRST_EN
    return i;
`else
    return 7 - i;
`endif
  endfunction

  task automatic half();
    repeat (5) @(negedge clock_50);
  endtask

  task automatic select_slave();
    SSEL = 1'b0;
    half();
  endtask

  task automatic deselect_slave();
    half();
    SSEL = 1'b1;
    half();
    half();
  endtask

  task automatic wait_rx_drain();
    int n;
    n = 0;
    while (rx_q.size() != 0 && n < 50) begin
      @(negedge clock_50);
      n++;
    end
  endtask

  // Mode-0 master: MOSI set while SCK low, MISO sampled just before each rising edge.
  task automatic spi_xfer(input logic [7:0] mosi_byte, input int nbits, output logic [7:0] miso_byte);
    miso_byte = 8'h00;
    if (nbits == 8) rx_q.push_back(mosi_byte);
    for (int i = 0; i < nbits; i++) begin
      MOSI = mosi_byte[bit_index(i)];
      half();
      miso_byte[bit_index(i)] = miso_w;
      SCK = 1'b1;
      if (i == 7) rise8_cycle = cycle;
      half();
      SCK = 1'b0;
    end
  endtask

  task automatic test_reset();
    logic [7:0] m;
    reset = 1'b0;
    repeat (3) @(negedge clock_50);
    tests++;
    if (miso_w !== 1'b0) begin failures++; $display("[TB] FAIL reset_miso: got %b, required released (0 via pulldown)", miso_w); end
    tests++;
    if (byte_received !== 1'b0) begin failures++; $display("[TB] FAIL reset_byte_received: got %b, required 0", byte_received); end
    tests++;
    if (byte_sent !== 1'b0) begin failures++; $display("[TB] FAIL reset_byte_sent: got %b, required 0", byte_sent); end
    tests++;
    if (byte_data_received !== 8'h00) begin failures++; $display("[TB] FAIL reset_data: got %02h, required 00", byte_data_received); end
    tests++;
    if (ssel_active !== 1'b0) begin failures++; $display("[TB] FAIL reset_ssel_active: got %b, required 0", ssel_active); end

    reset = 1'b1;
    repeat (3) @(negedge clock_50);
    select_slave();
    spi_xfer(8'h77, 8, m);
    wait_rx_drain();
    spi_xfer(8'hE0, 3, m);
    reset = 1'b0;
    @(negedge clock_50);
    tests++;
    if (miso_w !== 1'b0) begin failures++; $display("[TB] FAIL midreset_miso: got %b, required released (0 via pulldown)", miso_w); end
    tests++;
    if (byte_received !== 1'b0) begin failures++; $display("[TB] FAIL midreset_byte_received: got %b, required 0", byte_received); end
    tests++;
    if (byte_data_received !== 8'h00) begin failures++; $display("[TB] FAIL midreset_data: got %02h, required 00", byte_data_received); end
    SSEL = 1'b1;
    MOSI = 1'b0;
    repeat (3) @(negedge clock_50);
    reset = 1'b1;
    repeat (3) @(negedge clock_50);
    select_slave();
    spi_xfer(8'h5A, 8, m);
    wait_rx_drain();
    tests++;
    if (rx_q.size() != 0) begin failures++; $display("[TB] FAIL reset_recovery_drain: got %0d outstanding, required 0", rx_q.size()); rx_q.delete(); end
    tests++;
    if (byte_data_received !== 8'h5A) begin failures++; $display("[TB] FAIL reset_recovery_data: got %02h, required 5a", byte_data_received); end
    deselect_slave();
  endtask

  task automatic test_receive_burst();
    logic [7:0] m;
    select_slave();
    tests++;
    if (ssel_active !== 1'b1) begin failures++; $display("[TB] FAIL burst_ssel_active: got %b, required 1", ssel_active); end
    spi_xfer(8'h01, 8, m);
    spi_xfer(8'h12, 8, m);
    spi_xfer(8'h34, 8, m);
    wait_rx_drain();
    tests++;
    if (rx_q.size() != 0) begin failures++; $display("[TB] FAIL burst_drain: got %0d outstanding, required 0", rx_q.size()); rx_q.delete(); end
    deselect_slave();
    tests++;
    if (ssel_active !== 1'b0) begin failures++; $display("[TB] FAIL burst_deselect: got %b, required 0", ssel_active); end
  endtask

  task automatic test_transmit();
    logic [7:0] m;
    logic [7:0] e;
    int base;
    byte_send = 8'hC3;
    @(negedge clock_50);
    byte_send_ready = 1'b1;
    @(negedge clock_50);
    byte_send_ready = 1'b0;
    base = sent_count;
    tx_q.push_back(8'hC3);
    tx_q.push_back(8'hFF);
    select_slave();
    tests++;
    if ((sent_count - base) !== 1) begin failures++; $display("[TB] FAIL tx_sent_on_select: got %0d pulses, required 1", sent_count - base); end
    for (int k = 0; k < 2; k++) begin
      spi_xfer(8'h00, 8, m);
      e = tx_q.pop_front();
      tests++;
      if (m !== e) begin failures++; $display("[TB] FAIL tx_byte%0d: got %02h, required %02h", k, m, e); end
    end
    repeat (6) @(negedge clock_50);
    tests++;
    if ((sent_count - base) !== 1) begin failures++; $display("[TB] FAIL tx_sent_total: got %0d pulses, required 1", sent_count - base); end
    wait_rx_drain();
    deselect_slave();
  endtask

  task automatic test_level_ready();
    logic [7:0] m;
    logic [7:0] e;
    byte_send = 8'hA5;
    byte_send_ready = 1'b1;
    repeat (2) @(negedge clock_50);
    for (int k = 0; k < 3; k++) tx_q.push_back(8'hA5);
    select_slave();
    for (int k = 0; k < 3; k++) begin
      spi_xfer(8'h3C, 8, m);
      e = tx_q.pop_front();
      tests++;
      if (m !== e) begin failures++; $display("[TB] FAIL level_byte%0d: got %02h, required %02h", k, m, e); end
    end
    repeat (10) @(negedge clock_50);
    byte_send_ready = 1'b0;
    wait_rx_drain();
    deselect_slave();
  endtask

  task automatic test_abort();
    logic [7:0] m;
    select_slave();
    spi_xfer(8'hFF, 5, m);
    deselect_slave();
    repeat (10) @(negedge clock_50);
    tests++;
    if (byte_data_received !== 8'h3C) begin failures++; $display("[TB] FAIL abort_data_held: got %02h, required 3c", byte_data_received); end
    select_slave();
    spi_xfer(8'h03, 8, m);
    wait_rx_drain();
    tests++;
    if (rx_q.size() != 0) begin failures++; $display("[TB] FAIL abort_drain: got %0d outstanding, required 0", rx_q.size()); rx_q.delete(); end
    tests++;
    if (byte_data_received !== 8'h03) begin failures++; $display("[TB] FAIL abort_next_data: got %02h, required 03", byte_data_received); end
    deselect_slave();
  endtask

  task automatic test_idle_sck();
    SSEL = 1'b1;
    for (int i = 0; i < 16; i++) begin
      MOSI = 1'($urandom_range(0, 1));
      half();
      tests++;
      if (miso_w !== 1'b0 || ssel_active !== 1'b0) begin
        failures++;
        $display("[TB] FAIL idle_sck_step%0d: got miso=%b ssel_active=%b, required miso released and ssel_active=0", i, miso_w, ssel_active);
      end
      SCK = ~SCK;
    end
    SCK = 1'b0;
    repeat (10) @(negedge clock_50);
    tests++;
    if (byte_data_received !== 8'h03) begin failures++; $display("[TB] FAIL idle_sck_data_held: got %02h, required 03", byte_data_received); end
  endtask

`ifdef SPI_LSB_FIRST_EN
  task automatic test_lsb_first();
    logic [7:0] m;
    select_slave();
    spi_xfer(8'h01, 8, m);
    wait_rx_drain();
    tests++;
    if (byte_data_received !== 8'h01) begin failures++; $display("[TB] FAIL lsb_first_data: got %02h, required 01", byte_data_received); end
    deselect_slave();
  endtask
`endif

  initial begin
    test_reset();
    test_receive_burst();
    test_transmit();
    test_level_ready();
    test_abort();
    test_idle_sck();
`ifdef SPI_LSB_FIRST_EN
    test_lsb_first();
`endif
    repeat (5) @(negedge clock_50);
    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
